// File: rtl/alu_muldiv.sv
// alu_muldiv: registered ALU with iterative unsigned multiply/divide.
//
// Logic, add/sub and compare ops complete in one cycle. MULLO/MULHI use a
// shift-add multiplier and DIVU/REMU use a restoring divider. Both produce
// one bit per cycle, and the result appears WIDTH+1 cycles after accept.
// Operands and results each use a valid/ready handshake.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   Adat, Bdat, ALUoper   operands and opcode
//   out_valid / out_ready result handshake
//   Result                registered result
//   zero, carryout, overflow, div0, illegal
//                         result flags, meaningful only while out_valid
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Adat,
    input  logic [WIDTH-1:0] Bdat,
    input  logic [3:0]       ALUoper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow,
    output logic             div0,
    output logic             illegal
);

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpXor  = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpSltu = 4'd5;
    localparam logic [3:0] OpSub  = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Multiply: {partial high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic                   is_div_q, is_div_d;
    logic                   sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;
    logic                   div0_q, div0_d;
    logic                   illegal_q, illegal_d;
    logic                   res_load;

    logic                   accept;
    logic                   is_mul_op, is_div_op;

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign is_mul_op = (ALUoper[3:1] == 3'b100);
    assign is_div_op = (ALUoper[3:1] == 3'b101);

    // Single-cycle datapath.
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry, sc_ovf, sc_illegal;

    assign sum_add = {1'b0, Adat} + {1'b0, Bdat};
    assign sum_sub = {1'b0, Adat} + {1'b0, ~Bdat} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (ALUoper)
            OpAnd:  sc_result = Adat & Bdat;
            OpOr:   sc_result = Adat | Bdat;
            OpAdd: begin
                sc_result = sum_add[WIDTH-1:0];
                sc_carry  = sum_add[WIDTH];
                sc_ovf    = (Adat[WIDTH-1] == Bdat[WIDTH-1]) &
                            (sum_add[WIDTH-1] != Adat[WIDTH-1]);
            end
            OpXor:  sc_result = Adat ^ Bdat;
            OpNor:  sc_result = ~(Adat | Bdat);
            OpSltu: sc_result = {{(WIDTH-1){1'b0}}, (Adat < Bdat)};
            OpSub: begin
                sc_result = sum_sub[WIDTH-1:0];
                sc_carry  = sum_sub[WIDTH];
                sc_ovf    = (Adat[WIDTH-1] != Bdat[WIDTH-1]) &
                            (sum_sub[WIDTH-1] != Adat[WIDTH-1]);
            end
            OpSlt:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(Adat) < $signed(Bdat))};
            default: sc_illegal = (ALUoper[3:2] == 2'b11);
        endcase
    end

    // One iteration of the multiply or divide.
    logic [WIDTH:0]       mul_add;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_tmp, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;

    assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_add, acc_q[WIDTH-1:1]};

    // The partial remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits. The MSB of the difference is set exactly when a borrow occurs.
    assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_tmp - {1'b0, opnd_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};

    assign step_next = is_div_q ? div_next : mul_next;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;
        res_load  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (is_mul_op || (is_div_op && (Bdat != '0))) begin
                        acc_d    = {{WIDTH{1'b0}}, (is_div_op ? Adat : Bdat)};
                        opnd_d   = is_div_op ? Bdat : Adat;
                        is_div_d = is_div_op;
                        // MULHI and REMU both take the upper half of the accumulator.
                        sel_hi_d = ALUoper[0];
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = StBusy;
                    end else if (is_div_op) begin
                        res_load  = 1'b1;
                        result_d  = ALUoper[0] ? Adat : '1;
                        carry_d   = 1'b0;
                        ovf_d     = 1'b0;
                        div0_d    = 1'b1;
                        illegal_d = 1'b0;
                        state_d   = StDone;
                    end else begin
                        res_load  = 1'b1;
                        result_d  = sc_result;
                        carry_d   = sc_carry;
                        ovf_d     = sc_ovf;
                        div0_d    = 1'b0;
                        illegal_d = sc_illegal;
                        state_d   = StDone;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                acc_d = step_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_load  = 1'b1;
                    result_d  = sel_hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
                    carry_d   = 1'b0;
                    ovf_d     = 1'b0;
                    div0_d    = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        zero_d = res_load ? (result_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            sel_hi_q  <= sel_hi_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign Result   = result_q;
    assign zero     = zero_q;
    assign carryout = carry_q;
    assign overflow = ovf_q;
    assign div0     = div0_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32) against an arithmetic reference model.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Adat = '0;
    logic [31:0] Bdat = '0;
    logic [3:0]  ALUoper = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Result;
    logic        zero, carryout, overflow, div0, illegal;

    int checks = 0;
    int errors = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Adat      (Adat),
        .Bdat      (Bdat),
        .ALUoper   (ALUoper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .zero      (zero),
        .carryout  (carryout),
        .overflow  (overflow),
        .div0      (div0),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference model: flags packed as {zero, carryout, overflow, div0, illegal}.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
        longint unsigned ua, ub, p;
        longint          sa, sb, sr;
        logic            c, o, d, il;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 0; o = 0; d = 0; il = 0; r = '0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                p = ua + ub; r = 32'(p); c = (p >= 64'h1_0000_0000);
                sr = sa + sb; o = (sr > SMAX) || (sr < SMIN);
            end
            4'd3: r = a ^ b;
            4'd4: r = ~(a | b);
            4'd5: r = (a < b) ? 32'd1 : 32'd0;
            4'd6: begin
                p = ua - ub; r = 32'(p); c = (ua >= ub);
                sr = sa - sb; o = (sr > SMAX) || (sr < SMIN);
            end
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin p = ua * ub; r = 32'(p); end
            4'd9: begin p = ua * ub; r = 32'(p >> 32); end
            4'd10: if (b == 0) begin r = 32'hFFFF_FFFF; d = 1; end else r = a / b;
            4'd11: if (b == 0) begin r = a; d = 1; end else r = a % b;
            default: il = 1;
        endcase
        f = {(r == 32'd0), c, o, d, il};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd8 || op == 4'd9) return 33;
        if ((op == 4'd10 || op == 4'd11) && b != 0) return 33;
        return 1;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Issues one op from an idle, sampled (#1 after edge) point, waits for the result,
    // captures it, then drains it with a one-cycle out_ready pulse.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [4:0] f,
                         output int lat, output int nrdy);
        int n;
        ALUoper = op; Adat = a; Bdat = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; nrdy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) nrdy++;
            @(posedge clk); #1; lat++;
        end
        r = Result;
        f = {zero, carryout, overflow, div0, illegal};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({out_valid, Result, zero, carryout, overflow, div0, illegal} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b Result=%h flags=%b, want all zero",
                     out_valid, Result, {zero, carryout, overflow, div0, illegal});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [10] = '{4'd2, 4'd6, 4'd7, 4'd5, 4'd9, 4'd8, 4'd10, 4'd11, 4'd10, 4'd13};
        logic [31:0] as   [10] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd3};
        logic [31:0] bs   [10] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd7, 32'd7, 32'd0, 32'd4};
        logic [31:0] exp_r[10] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'd1,
                                   32'd14, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [4:0]  exp_f[10] = '{5'b00100, 5'b11000, 5'b00000, 5'b10000, 5'b00000, 5'b00000,
                                   5'b00000, 5'b00000, 5'b00010, 5'b10001};
        int          exp_l[10] = '{1, 1, 1, 1, 33, 33, 33, 33, 1, 1};
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, nrdy;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], as[i], bs[i], r, f, lat, nrdy);
            checks++;
            if ({r, f, lat, nrdy} !== {exp_r[i], exp_f[i], exp_l[i], exp_l[i] - 1}) begin
                errors++;
                $display("FAIL directed_%0d: op=%0d got r=%h f=%b lat=%0d nrdy=%0d, want r=%h f=%b lat=%0d nrdy=%0d",
                         i, ops[i], r, f, lat, nrdy, exp_r[i], exp_f[i], exp_l[i], exp_l[i] - 1);
            end
        end
    endtask

    task automatic test_random_single();
        logic [3:0]  op;
        logic [31:0] a, b, r, er;
        logic [4:0]  f, ef;
        int          lat, nrdy;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op >= 4'd8) op = op + 4'd4;
            a = rnd32(); b = rnd32();
            model(op, a, b, er, ef);
            do_op(op, a, b, r, f, lat, nrdy);
            checks++;
            if ({r, f, lat} !== {er, ef, 32'd1}) begin
                errors++;
                $display("FAIL single_%0d: op=%0d a=%h b=%h got r=%h f=%b lat=%0d, want r=%h f=%b lat=1",
                         i, op, a, b, r, f, lat, er, ef);
            end
        end
    endtask

    task automatic test_random_muldiv();
        logic [3:0]  op;
        logic [31:0] a, b, r, er;
        logic [4:0]  f, ef;
        int          lat, nrdy, el;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(8, 11));
            a = rnd32();
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : rnd32();
            model(op, a, b, er, ef);
            el = model_lat(op, b);
            do_op(op, a, b, r, f, lat, nrdy);
            checks++;
            if ({r, f, lat, nrdy} !== {er, ef, el, el - 1}) begin
                errors++;
                $display("FAIL muldiv_%0d: op=%0d a=%h b=%h got r=%h f=%b lat=%0d nrdy=%0d, want r=%h f=%b lat=%0d nrdy=%0d",
                         i, op, a, b, r, f, lat, nrdy, er, ef, el, el - 1);
            end
        end
    endtask

    task automatic test_hold_then_accept();
        logic [31:0] er, a, b;
        logic [4:0]  ef;
        a = $urandom(); b = $urandom();
        model(4'd2, a, b, er, ef);
        ALUoper = 4'd2; Adat = a; Bdat = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, Result, zero, carryout, overflow, div0, illegal} !==
                {1'b1, 1'b0, er, ef}) begin
                errors++;
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b Result=%h f=%b, want 1/0 %h %b",
                         i, out_valid, in_ready, Result,
                         {zero, carryout, overflow, div0, illegal}, er, ef);
            end
            @(posedge clk); #1;
        end
        a = $urandom(); b = $urandom();
        ALUoper = 4'd0; Adat = a; Bdat = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if ({out_valid, Result} !== {1'b1, a & b}) begin
            errors++;
            $display("FAIL hold_and_result: out_valid=%b Result=%h, want 1 %h",
                     out_valid, Result, a & b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b, er;
        logic [4:0]  ef;
        int          n;
        op = 4'd2; a = $urandom(); b = $urandom();
        model(op, a, b, er, ef);
        ALUoper = op; Adat = a; Bdat = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
            checks++;
            if ({out_valid, Result, zero, carryout, overflow, div0, illegal} !== {1'b1, er, ef}) begin
                errors++;
                $display("FAIL b2b_%0d: out_valid=%b Result=%h f=%b, want 1 %h %b", i, out_valid,
                         Result, {zero, carryout, overflow, div0, illegal}, er, ef);
            end
            op = 4'($urandom_range(0, 11));
            a = rnd32(); b = rnd32();
            model(op, a, b, er, ef);
            ALUoper = op; Adat = a; Bdat = b; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if ({out_valid, Result, zero, carryout, overflow, div0, illegal} !== {1'b1, er, ef}) begin
            errors++;
            $display("FAIL b2b_last: out_valid=%b Result=%h, want 1 %h", out_valid, Result, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, nrdy;
        ALUoper = 4'd10; Adat = $urandom(); Bdat = 32'd3 + 32'($urandom_range(0, 1000));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Result, zero, carryout, overflow, div0, illegal} !== 38'd0) begin
            errors++;
            $display("FAIL abort_reset: out_valid=%b Result=%h, want 0 0", out_valid, Result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL abort_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        do_op(4'd2, 32'd2, 32'd3, r, f, lat, nrdy);
        checks++;
        if ({r, lat} !== {32'd5, 32'd1}) begin
            errors++;
            $display("FAIL abort_add: Result=%h lat=%0d, want 5 1", r, lat);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, nrdy;
        for (int op = 12; op < 16; op++) begin
            do_op(4'(op), $urandom(), $urandom(), r, f, lat, nrdy);
            checks++;
            if ({r, f, lat} !== {32'd0, 5'b10001, 32'd1}) begin
                errors++;
                $display("FAIL illegal_%0d: Result=%h f=%b lat=%0d, want 0 10001 1", op, r, f, lat);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_random_single();
        test_random_muldiv();
        test_hold_then_accept();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
